// File: rtl/led_matrix_scan_phy.sv
// led_matrix_scan_phy: HUB75 BCM scan engine (frame RAM -> panel pins); define LED_SCAN_DBLBUF_EN for frame_sel_in double buffering
module led_matrix_scan_phy #(
  parameter int NUM_COLS = 64,
  parameter int NUM_SCAN_ROWS = 16,
  parameter int NUM_CHAN = 2,
  parameter int COLOUR_BITS = 8,
  parameter int BCLK_DIV = 4,
  parameter int RAM_LATENCY = 2,
  parameter int OE_BASE = 32,
  localparam int AW = $clog2(NUM_SCAN_ROWS * NUM_COLS),
  localparam int RW = $clog2(NUM_SCAN_ROWS),
  localparam int NL = NUM_CHAN * 3,
  localparam int DATW = NL * COLOUR_BITS
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            enable_in,
`ifdef LED_SCAN_DBLBUF_EN
  input  logic            frame_sel_in,
  output logic [AW:0]     rd_addr_out,
`else
  output logic [AW-1:0]   rd_addr_out,
`endif
  output logic            rd_en_out,
  input  logic [DATW-1:0] rd_data_in,
  output logic [NL-1:0]   rgb_out,
  output logic            bit_clk_out,
  output logic            latch_enable_out,
  output logic            oe_n_out,
  output logic [RW-1:0]   addr_out,
  output logic            busy_out,
  output logic            frame_done_out
);
  localparam int CW = $clog2(NUM_COLS);
  localparam int PW = COLOUR_BITS > 1 ? $clog2(COLOUR_BITS) : 1;
  localparam int DW = $clog2((OE_BASE << (COLOUR_BITS - 1)) + BCLK_DIV + RAM_LATENCY) + 1;
  typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT, LATCH, DISPLAY} state_t;
  state_t state;
  logic [RW-1:0] row, nrow;
  logic [PW-1:0] plane;
  logic [CW-1:0] col;
  logic [DW-1:0] cnt, oe_len;
  logic [AW-1:0] rd_addr;
  logic [DATW-1:0] hold, col_data;
  logic last_plane, last_row, last_ph, cap, disp_end, frame_end, leave_idle;
  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input int c);
    return AW'(int'(r) * NUM_COLS + c);
  endfunction
  function automatic logic [NL-1:0] bits_of(input logic [DATW-1:0] d, input logic [PW-1:0] p);
    for (int k = 0; k < NL; k++)
      bits_of[k] = |(d[k*COLOUR_BITS +: COLOUR_BITS] & (COLOUR_BITS'(1) << p));
  endfunction
  always_comb begin
    last_plane = plane == PW'(COLOUR_BITS - 1);
    last_row = row == RW'(NUM_SCAN_ROWS - 1);
    last_ph = cnt == DW'(BCLK_DIV - 1);
    cap = cnt == DW'(RAM_LATENCY);
    oe_len = DW'(OE_BASE) << plane;
    disp_end = state == DISPLAY && cnt == oe_len - 1'b1;
    frame_end = disp_end && last_plane && last_row;
    leave_idle = state == IDLE && enable_in;
    nrow = !last_plane ? row : last_row ? '0 : row + 1'b1;
    col_data = cap ? rd_data_in : hold;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
      row <= '0;
      plane <= '0;
      col <= '0;
      cnt <= '0;
      hold <= '0;
      rd_addr <= '0;
      rd_en_out <= 1'b0;
      rgb_out <= '0;
      bit_clk_out <= 1'b0;
      latch_enable_out <= 1'b0;
      oe_n_out <= 1'b1;
      addr_out <= '0;
      busy_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      rd_en_out <= 1'b0;
      frame_done_out <= 1'b0;
      case (state)
        IDLE: if (leave_idle) begin
          state <= PREFETCH;
          busy_out <= 1'b1;
          rd_en_out <= 1'b1;
          rd_addr <= addr_of(row, 0);
          cnt <= '0;
        end
        PREFETCH: begin
          cnt <= cnt + 1'b1;
          if (cap) begin
            state <= SHIFT;
            cnt <= '0;
            col <= '0;
            rgb_out <= bits_of(rd_data_in, plane);
            bit_clk_out <= 1'b0;
            rd_en_out <= 1'b1;
            rd_addr <= addr_of(row, 1);
          end
        end
        SHIFT: begin
          // Data for the next column may land on the same edge the period ends
          cnt <= last_ph ? '0 : cnt + 1'b1;
          bit_clk_out <= !last_ph && (cnt + 1'b1 >= DW'(BCLK_DIV / 2));
          if (cap) hold <= rd_data_in;
          if (last_ph) begin
            if (col == CW'(NUM_COLS - 1)) begin
              state <= LATCH;
              latch_enable_out <= 1'b1;
              addr_out <= row;
            end else begin
              col <= col + 1'b1;
              rgb_out <= bits_of(col_data, plane);
              if (int'(col) + 2 < NUM_COLS) begin
                rd_en_out <= 1'b1;
                rd_addr <= addr_of(row, int'(col) + 2);
              end
            end
          end
        end
        LATCH: begin
          state <= DISPLAY;
          latch_enable_out <= 1'b0;
          oe_n_out <= 1'b0;
          cnt <= '0;
        end
        DISPLAY: begin
          cnt <= cnt + 1'b1;
          if (disp_end) begin
            oe_n_out <= 1'b1;
            cnt <= '0;
            plane <= last_plane ? '0 : plane + 1'b1;
            row <= nrow;
            frame_done_out <= frame_end;
            if (frame_end && !enable_in) begin
              state <= IDLE;
              busy_out <= 1'b0;
            end else begin
              state <= PREFETCH;
              rd_en_out <= 1'b1;
              rd_addr <= addr_of(nrow, 0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LED_SCAN_DBLBUF_EN
  logic fsel;
  always_ff @(posedge clk_in)
    if (reset_in) fsel <= 1'b0;
    else if (leave_idle || frame_end) fsel <= frame_sel_in;
  assign rd_addr_out = {fsel, rd_addr};
`else
  assign rd_addr_out = rd_addr;
`endif
endmodule

// File: tb/tb_led_matrix_scan_phy.sv
// tb_led_matrix_scan_phy: directed bench for led_matrix_scan_phy with a small-geometry panel
module tb_led_matrix_scan_phy;
  localparam int AW = 3;
  logic clk_in = 1'b0, reset_in = 1'b1, enable_in = 1'b0;
`ifdef LED_SCAN_DBLBUF_EN
  logic frame_sel_in = 1'b0;
  logic [AW:0] rd_addr_out;
`else
  logic [AW-1:0] rd_addr_out;
`endif
  logic rd_en_out, bit_clk_out, latch_enable_out, oe_n_out, busy_out, frame_done_out;
  logic [11:0] rd_data_in = '0;
  logic [5:0] rgb_out;
  logic [0:0] addr_out;
  logic [11:0] ram [8];
  int total = 0, bad = 0;
  always #5 clk_in = ~clk_in;

  led_matrix_scan_phy #(.NUM_COLS(4), .NUM_SCAN_ROWS(2), .NUM_CHAN(2), .COLOUR_BITS(2),
    .BCLK_DIV(2), .RAM_LATENCY(1), .OE_BASE(4)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
`ifdef LED_SCAN_DBLBUF_EN
    .frame_sel_in(frame_sel_in),
`endif
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .rgb_out(rgb_out), .bit_clk_out(bit_clk_out), .latch_enable_out(latch_enable_out),
    .oe_n_out(oe_n_out), .addr_out(addr_out), .busy_out(busy_out), .frame_done_out(frame_done_out));

  always @(posedge clk_in) if (rd_en_out) rd_data_in <= ram[rd_addr_out[AW-1:0]];

  logic [5:0] rises_q[$];
  int rd_q[$], oe_runs[$], addr_q[$];
  int latch_n = 0, done_n = 0, bad_mon = 0, oe_run = 0;
  logic bc_d = 1'b0, oe_d = 1'b1;
  logic [0:0] addr_d = '0;
  always @(negedge clk_in) begin
    if (reset_in) oe_run = 0;
    else begin
      if (bit_clk_out && !bc_d) rises_q.push_back(rgb_out);
      if (rd_en_out) rd_q.push_back(int'(rd_addr_out));
      if (!oe_n_out) begin
        if (oe_d) addr_q.push_back(int'(addr_out));
        oe_run++;
      end else if (!oe_d) begin
        oe_runs.push_back(oe_run);
        oe_run = 0;
      end
      if (latch_enable_out) begin
        latch_n++;
        if (bit_clk_out || !oe_n_out) bad_mon++;
      end
      if (rd_en_out && (latch_enable_out || !oe_n_out)) bad_mon++;
      if (addr_out != addr_d && (!oe_n_out || !oe_d)) bad_mon++;
      if (frame_done_out) done_n++;
    end
    bc_d = bit_clk_out;
    oe_d = oe_n_out;
    addr_d = addr_out;
  end

  int exp_rd[16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
  int exp_oe[4] = '{4, 8, 4, 8};
  int exp_row[4] = '{0, 0, 1, 1};
  logic [5:0] exp_b[16] = '{6'h00, 6'h3F, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h3F, 6'h3F,
                            6'h3F, 6'h00, 6'h3F, 6'h00, 6'h3F, 6'h3F, 6'h00, 6'h00};
  logic [11:0] ram_c[8] = '{12'hA5C, 12'h3C6, 12'h1E9, 12'hF03, 12'h5A5, 12'h0FF, 12'hC33, 12'h96A};
  int rb, db, ob, ab, lb, fb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    rb = rises_q.size(); db = rd_q.size(); ob = oe_runs.size();
    ab = addr_q.size(); lb = latch_n; fb = done_n;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (!frame_done_out && n < lim) begin
      @(negedge clk_in);
      n++;
    end
    chk(tag, 32'(frame_done_out), 1);
  endtask

  task automatic check_frames(input string tag, input int nf);
    chk({tag, "_nrd"}, rd_q.size() - db, 16 * nf);
    chk({tag, "_noe"}, oe_runs.size() - ob, 4 * nf);
    chk({tag, "_nrise"}, rises_q.size() - rb, 16 * nf);
    chk({tag, "_nlatch"}, latch_n - lb, 4 * nf);
    chk({tag, "_ndone"}, done_n - fb, nf);
    chk({tag, "_proto"}, bad_mon, 0);
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < 16; i++) chk({tag, "_rdaddr"}, rd_q[db + f*16 + i] % 8, exp_rd[i]);
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_oelen"}, oe_runs[ob + f*4 + i], exp_oe[i]);
        chk({tag, "_row"}, addr_q[ab + f*4 + i], exp_row[i]);
      end
    end
  endtask

  function automatic logic [5:0] rgb_of(input logic [11:0] w, input int p);
    logic [11:0] s;
    s = w >> p;
    for (int k = 0; k < 6; k++) rgb_of[k] = s[k*2];
  endfunction

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_oe_n", 32'(oe_n_out), 1);
    chk("rst_rd_en", 32'(rd_en_out), 0);
    chk("rst_rd_addr", 32'(rd_addr_out), 0);
    chk("rst_rgb", 32'(rgb_out), 0);
    chk("rst_bclk", 32'(bit_clk_out), 0);
    chk("rst_le", 32'(latch_enable_out), 0);
    chk("rst_addr", 32'(addr_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_done", 32'(frame_done_out), 0);
    reset_in = 1'b0;
    @(negedge clk_in);
    chk("idle_busy", 32'(busy_out), 0);
    // all ones, single enable pulse: one full frame then idle
    for (int a = 0; a < 8; a++) ram[a] = 12'hFFF;
    mark();
    enable_in = 1'b1;
    @(negedge clk_in);
    enable_in = 1'b0;
    chk("a_busy", 32'(busy_out), 1);
    wait_done("a_done", 400);
    chk("a_busy_end", 32'(busy_out), 0);
    @(negedge clk_in);
    chk("a_pulse", 32'(frame_done_out), 0);
    chk("a_idle", 32'(busy_out), 0);
    check_frames("a", 1);
    for (int i = 0; i < 16; i++) chk("a_rgb", 32'(rises_q[rb + i]), 32'h3F);
    repeat (10) @(negedge clk_in);
    chk("a_no_rd_idle", rd_q.size() - db, 16);
    // column ramp, enable dropped mid row 0
    for (int c = 0; c < 4; c++) begin
      ram[c] = {6{2'(c)}};
      ram[4 + c] = {6{2'(3 - c)}};
    end
    mark();
    enable_in = 1'b1;
    repeat (10) @(negedge clk_in);
    enable_in = 1'b0;
    wait_done("b_done", 400);
    @(negedge clk_in);
    chk("b_pulse", 32'(frame_done_out), 0);
    chk("b_idle", 32'(busy_out), 0);
    check_frames("b", 1);
    for (int i = 0; i < 16; i++) chk("b_rgb", 32'(rises_q[rb + i]), 32'(exp_b[i]));
    // distinct lane/colour bits, two back-to-back frames
    for (int a = 0; a < 8; a++) ram[a] = ram_c[a];
    mark();
    enable_in = 1'b1;
    wait_done("c_done1", 400);
    chk("c_busy_cont", 32'(busy_out), 1);
    enable_in = 1'b0;
    @(negedge clk_in);
    chk("c_pulse", 32'(frame_done_out), 0);
    wait_done("c_done2", 400);
    @(negedge clk_in);
    chk("c_idle", 32'(busy_out), 0);
    check_frames("c", 2);
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 2; r++)
        for (int p = 0; p < 2; p++)
          for (int c = 0; c < 4; c++)
            chk("c_rgb", 32'(rises_q[rb + f*16 + r*8 + p*4 + c]), 32'(rgb_of(ram_c[r*4 + c], p)));
`ifdef LED_SCAN_DBLBUF_EN
    mark();
    frame_sel_in = 1'b0;
    enable_in = 1'b1;
    repeat (20) @(negedge clk_in);
    frame_sel_in = 1'b1;
    wait_done("d_done1", 400);
    enable_in = 1'b0;
    @(negedge clk_in);
    wait_done("d_done2", 400);
    @(negedge clk_in);
    chk("d_nrd", rd_q.size() - db, 32);
    for (int i = 0; i < 32; i++) chk("d_sel", rd_q[db + i] / 8, i < 16 ? 0 : 1);
`endif
    // reset mid-scan
    enable_in = 1'b1;
    repeat (30) @(negedge clk_in);
    chk("m_busy", 32'(busy_out), 1);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("m_oe_n", 32'(oe_n_out), 1);
    chk("m_busy_rst", 32'(busy_out), 0);
    chk("m_rd_en", 32'(rd_en_out), 0);
    chk("m_rgb", 32'(rgb_out), 0);
    chk("m_bclk", 32'(bit_clk_out), 0);
    chk("m_le", 32'(latch_enable_out), 0);
    chk("m_addr", 32'(addr_out), 0);
    reset_in = 1'b0;
    enable_in = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("m_idle", 32'(busy_out), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
